// File: rtl/operand_register_file.sv
// Eight-entry operand register file with a one-stage write-back register and a masked status latch.
// Optional macro WB_FORWARD_EN forwards the pending write-back value onto OprdA/OprdB.
module operand_register_file #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [AW-1:0] SA,
    input  logic [AW-1:0] SB,
    input  logic          MB,
    input  logic [DW-1:0] ConstIn,
    input  logic [AW-1:0] DA,
    input  logic          WE,
    input  logic [DW-1:0] FOut,
    input  logic          Z,
    input  logic          C,
    input  logic          V,
    input  logic          N,
    input  logic          D,
    input  logic [4:0]    FlagMask,
    output logic [DW-1:0] OprdA,
    output logic [DW-1:0] OprdB,
    output logic [4:0]    Status,
    output logic          WbPending
);
    localparam int NREG = 1 << AW;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_addr_q,  wb_addr_d;
    logic [DW-1:0] wb_data_q,  wb_data_d;
    logic [4:0]    status_q,   status_d;
    logic [4:0]    flags;

    assign flags = {D, N, V, C, Z};

    // Commit from the write-back stage; a new capture on the same edge is independent.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (wb_valid_q && (wb_addr_q == AW'(gi))) begin
                    regs_d[gi] = wb_data_q;
                end
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        wb_valid_d = WE;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (WE) begin
            wb_addr_d = DA;
            wb_data_d = FOut;
        end
        status_d = (status_q & ~FlagMask) | (flags & FlagMask);
    end

    // Address/data of the stage need no reset: they are only consumed while valid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wb_valid_q <= 1'b0;
            status_q   <= 5'b00000;
        end else begin
            wb_valid_q <= wb_valid_d;
            status_q   <= status_d;
        end
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_data_d;
    end

    always_comb begin
        OprdA = regs_q[SA];
        OprdB = MB ? ConstIn : regs_q[SB];
`ifdef WB_FORWARD_EN
        if (wb_valid_q && (SA == wb_addr_q)) begin
            OprdA = wb_data_q;
        end
        if (wb_valid_q && !MB && (SB == wb_addr_q)) begin
            OprdB = wb_data_q;
        end
`endif
    end

    assign Status    = status_q;
    assign WbPending = wb_valid_q;

endmodule

// File: tb/tb_operand_register_file.sv
// Randomized and directed bench for operand_register_file against a queue-based reference model.
module tb_operand_register_file;
    logic       Clk;
    logic       Reset;
    logic [2:0] SA, SB, DA;
    logic       MB, WE;
    logic [7:0] ConstIn, FOut;
    logic       Z, C, V, N, D;
    logic [4:0] FlagMask;
    logic [7:0] OprdA, OprdB;
    logic [4:0] Status;
    logic       WbPending;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    logic [7:0] mem [8];
    wr_t        pend [$];
    logic [4:0] m_status;

    operand_register_file #(.DW(8), .AW(3)) dut (
        .Clk(Clk), .Reset(Reset), .SA(SA), .SB(SB), .MB(MB), .ConstIn(ConstIn),
        .DA(DA), .WE(WE), .FOut(FOut), .Z(Z), .C(C), .V(V), .N(N), .D(D),
        .FlagMask(FlagMask), .OprdA(OprdA), .OprdB(OprdB), .Status(Status),
        .WbPending(WbPending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference: a write captured on one edge becomes array content on the next edge.
    function automatic logic [7:0] exp_reg(input logic [2:0] a, input logic fwd);
        if (fwd && pend.size() > 0 && pend[0].addr == a) return pend[0].data;
        return mem[a];
    endfunction

    function automatic logic fwd_en();
`ifdef WB_FORWARD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Advance one clock edge, updating the model from the inputs presented before it.
    task automatic step();
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'h00;
            pend.delete();
            m_status = 5'b00000;
        end else begin
            if (pend.size() > 0) begin
                mem[pend[0].addr] = pend[0].data;
                void'(pend.pop_front());
            end
            if (WE) pend.push_back('{addr: DA, data: FOut});
            m_status = (m_status & ~FlagMask) | ({D, N, V, C, Z} & FlagMask);
        end
        #1;
    endtask

    task automatic idle_inputs();
        Reset = 0; WE = 0; MB = 0; FlagMask = 5'b00000;
        {Z, C, V, N, D} = 5'b00000;
        SA = 0; SB = 0; DA = 0; ConstIn = 0; FOut = 0;
    endtask

    task automatic do_reset();
        Reset = 1;
        step();
        Reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        SA = 3; SB = 6; #1;
        n_vec++;
        if (OprdA !== 8'h00 || OprdB !== 8'h00 || Status !== 5'b0 || WbPending !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: A=%h B=%h St=%b P=%b required 00 00 00000 0", OprdA, OprdB, Status, WbPending);
        end
        WE = 1; DA = 3; FOut = 8'h7A; step();
        WE = 0; step();
        n_vec++;
        if (OprdA !== 8'h7A) begin
            n_err++;
            $display("FAIL reset_prewrite: R3=%h required 7a", OprdA);
        end
        WE = 1; DA = 4; FOut = 8'h55; step();
        WE = 1; DA = 5; FOut = 8'h66; FlagMask = 5'b11111; {Z, C, V, N, D} = 5'b11111;
        Reset = 1; step();
        Reset = 0; WE = 0; FlagMask = 0; {Z, C, V, N, D} = 5'b00000;
        SA = 3; SB = 4; #1;
        n_vec++;
        if (OprdA !== 8'h00 || OprdB !== 8'h00 || Status !== 5'b0 || WbPending !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clear: A=%h B=%h St=%b P=%b required 00 00 00000 0", OprdA, OprdB, Status, WbPending);
        end
        step(); SA = 4; SB = 5; #1;
        n_vec++;
        if (OprdA !== 8'h00 || OprdB !== 8'h00) begin
            n_err++;
            $display("FAIL reset_discard: R4=%h R5=%h required 00 00", OprdA, OprdB);
        end
    endtask

    task automatic test_basic();
        idle_inputs(); do_reset();
        WE = 1; DA = 2; FOut = 8'h52; step();
        WE = 0; step();
        SA = 2; #1;
        n_vec++;
        if (OprdA !== 8'h52) begin
            n_err++;
            $display("FAIL basic_read: OprdA=%h required 52", OprdA);
        end
        for (int s = 0; s < 8; s++) begin
            MB = 1; ConstIn = 8'hCC; SB = s[2:0]; #1;
            n_vec++;
            if (OprdB !== 8'hCC) begin
                n_err++;
                $display("FAIL basic_const sb=%0d: OprdB=%h required cc", s, OprdB);
            end
        end
        MB = 0; SB = 2; #1;
        n_vec++;
        if (OprdB !== 8'h52) begin
            n_err++;
            $display("FAIL basic_readb: OprdB=%h required 52", OprdB);
        end
    endtask

    task automatic test_forward();
        logic [7:0] want;
        idle_inputs(); do_reset();
        WE = 1; DA = 5; FOut = 8'hA5; step();
        WE = 0; SA = 5; SB = 5; MB = 0; #1;
        want = fwd_en() ? 8'hA5 : 8'h00;
        n_vec++;
        if (OprdA !== want || OprdB !== want) begin
            n_err++;
            $display("FAIL forward: A=%h B=%h required %h %h", OprdA, OprdB, want, want);
        end
        MB = 1; ConstIn = 8'h3C; #1;
        n_vec++;
        if (OprdB !== 8'h3C) begin
            n_err++;
            $display("FAIL forward_const: OprdB=%h required 3c", OprdB);
        end
        MB = 0; step(); #1;
        n_vec++;
        if (OprdA !== 8'hA5 || OprdB !== 8'hA5) begin
            n_err++;
            $display("FAIL forward_commit: A=%h B=%h required a5 a5", OprdA, OprdB);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        idle_inputs(); do_reset();
        SA = 1;
        WE = 1; DA = 1; FOut = 8'h11; step();
        n_vec++;
        if (WbPending !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_pend_t1: WbPending=%b required 1", WbPending);
        end
        FOut = 8'h22; step();
        want = fwd_en() ? 8'h22 : 8'h11;
        n_vec++;
        if (WbPending !== 1'b1 || OprdA !== want) begin
            n_err++;
            $display("FAIL b2b_t2: P=%b R1=%h required 1 %h", WbPending, OprdA, want);
        end
        WE = 0; step();
        n_vec++;
        if (WbPending !== 1'b0 || OprdA !== 8'h22) begin
            n_err++;
            $display("FAIL b2b_t3: P=%b R1=%h required 0 22", WbPending, OprdA);
        end
    endtask

    task automatic test_flags();
        idle_inputs(); do_reset();
        {Z, C, V, N, D} = 5'b11010; FlagMask = 5'b11111; step();
        n_vec++;
        if (Status !== 5'b01011) begin
            n_err++;
            $display("FAIL flags_all: Status=%b required 01011", Status);
        end
        {Z, C, V, N, D} = 5'b00000; FlagMask = 5'b00001; step();
        n_vec++;
        if (Status !== 5'b01010) begin
            n_err++;
            $display("FAIL flags_masked: Status=%b required 01010", Status);
        end
    endtask

    task automatic test_simul_commit();
        idle_inputs(); do_reset();
        for (int i = 0; i < 4; i++) begin
            WE = 1; DA = i[2:0]; FOut = 8'(i + 1); step();
        end
        WE = 0; step(); step();
        for (int i = 0; i < 4; i++) begin
            SA = i[2:0]; SB = 3'(3 - i); #1;
            n_vec++;
            if (OprdA !== 8'(i + 1) || OprdB !== 8'(4 - i)) begin
                n_err++;
                $display("FAIL simul_commit r%0d: A=%h B=%h required %h %h", i, OprdA, OprdB, 8'(i + 1), 8'(4 - i));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ea, eb;
        idle_inputs(); do_reset();
        for (int k = 0; k < 400; k++) begin
            Reset    = ($urandom_range(0, 40) == 0);
            WE       = $urandom_range(0, 3) != 0;
            DA       = 3'($urandom);
            FOut     = 8'($urandom);
            SA       = 3'($urandom);
            SB       = $urandom_range(0, 3) == 0 ? DA : 3'($urandom);
            MB       = $urandom_range(0, 4) == 0;
            ConstIn  = 8'($urandom);
            {Z, C, V, N, D} = 5'($urandom);
            FlagMask = 5'($urandom);
            #1;
            ea = exp_reg(SA, fwd_en());
            eb = MB ? ConstIn : exp_reg(SB, fwd_en());
            n_vec++;
            if (OprdA !== ea || OprdB !== eb || Status !== m_status || WbPending !== (pend.size() > 0)) begin
                n_err++;
                $display("FAIL random #%0d: A=%h B=%h St=%b P=%b required %h %h %b %b",
                         k, OprdA, OprdB, Status, WbPending, ea, eb, m_status, pend.size() > 0);
            end
            step();
        end
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        m_status = 5'b0;
        @(negedge Clk);
        test_reset();
        test_basic();
        test_forward();
        test_back_to_back();
        test_flags();
        test_simul_commit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/operand_register_file.md
# operand_register_file

- Sits between the control unit and the ALU.
- Holds the eight general-purpose 8-bit registers R0–R7 and sources OprdA/OprdB to the ALU, with OprdB optionally replaced by an immediate constant.
- Captures ALU FOut through a one-stage write-back register and commits it to the array.
- Latches the ALU flags Z, C, V, N, D into a masked status register consumed by branch logic.

## Interface

Parameters:
- DW, 8, data width (matches ALU operand width)
- AW, 3, register address width (2**AW registers)

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- SA  in  AW  register select for OprdA
- SB  in  AW  register select for OprdB
- MB  in  1  0: OprdB from register SB; 1: OprdB = ConstIn
- ConstIn  in  DW  immediate operand from the instruction word
- DA  in  AW  destination register for the current FOut
- WE  in  1  capture FOut/DA into the write-back stage this cycle
- FOut  in  DW  ALU result
- Z, C, V, N, D  in  1 each  ALU flags for the current operation
- FlagMask  in  5  per-flag update enable, bit order {D,N,V,C,Z}
- OprdA  out  DW  operand A to ALU (combinational)
- OprdB  out  DW  operand B to ALU (combinational)
- Status  out  5  latched flags {D,N,V,C,Z}
- WbPending  out  1  write-back stage holds an uncommitted write

## Operation

- Register array: 2**AW × DW words, written only from the write-back stage.
- Write-back stage: WbValid, WbAddr, WbData.
  - On an edge with WE=1: WbValid<=1, WbAddr<=DA, WbData<=FOut.
  - On an edge with WE=0: WbValid<=0.
- Commit: on every edge with WbValid=1, array[WbAddr]<=WbData.
  - A commit and a new capture occur on the same edge independently, so back-to-back writes sustain one per cycle.
- Reads:
  - OprdA = array[SA].
  - OprdB = MB ? ConstIn : array[SB].
  - Both are modified by forwarding (see Configuration).
- Status:
  - On each edge, Status[i]<=flag_i where FlagMask[i]=1; bits with FlagMask[i]=0 hold.
  - Flags are not pipelined; they reflect the operation presented in the same cycle as the mask.
- WbPending = WbValid.
- No read-port conflicts exist: SA=SB is legal and both outputs return the same value.
- Consecutive writes to the same DA: the later value wins, with ordering preserved by the pipeline.

## Timing

- Reset (synchronous, edge with Reset=1):
  - All array words <= 0, Status <= 5'b00000, WbValid <= 0.
  - A pending write is discarded and is not committed.
  - WE and FlagMask are ignored on that edge.
- Out of reset: OprdA=0, OprdB=0 (MB=0) or ConstIn (MB=1), Status=0, WbPending=0.
- Write latency:
  - FOut presented with WE=1 in cycle t is held in the write-back stage during t+1.
  - It is in the array from t+2.
  - With forwarding it is readable in cycle t+1.
- Flag latency: flags presented in cycle t appear on Status in cycle t+1.
- Read path: purely combinational from SA/SB/MB/ConstIn and stored state; no clock latency.

## Configuration

- Macro: WB_FORWARD_EN.
- Defined:
  - If WbValid=1 and SA==WbAddr, OprdA=WbData.
  - If WbValid=1, MB=0 and SB==WbAddr, OprdB=WbData.
  - ConstIn is never overridden.
- Undefined:
  - Reads return array contents only.
  - A read in cycle t+1 of a register written in cycle t returns the stale value; the control unit must insert one idle cycle.
- WbPending behaviour is identical in both builds.

## Test plan

- Reset: write 8'h7A to R3, then assert Reset for one edge → OprdA=8'h00 with SA=3, Status=5'b00000, WbPending=0. A write captured on the edge before Reset is never committed.
- Basic write/read: DA=2, FOut=8'h52, WE=1 at t; SA=2 at t+2 → OprdA=8'h52. MB=1, ConstIn=8'hCC → OprdB=8'hCC regardless of SB.
- Forwarding (WB_FORWARD_EN defined): DA=5, FOut=8'hA5, WE=1 at t; SA=5, SB=5 at t+1 → OprdA=OprdB=8'hA5. Without the macro, both return the prior R5 value (8'h00 after reset).
- Back-to-back same destination: WE=1, DA=1 with FOut=8'h11 at t and 8'h22 at t+1 → R1=8'h22 from t+3; WbPending high during t+1 and t+2, low at t+3.
- Masked flags: Z=1, C=1, V=0, N=1, D=0 with FlagMask=5'b11111 → Status=5'b01011. Next cycle all flags 0 with FlagMask=5'b00001 → Status=5'b01010.
- Simultaneous capture and commit: WE=1 on four consecutive cycles to R0..R3 with 8'h01..8'h04 → all four registers hold those values two cycles after the last capture; no write is lost.
